result_dumper: RTL

Transmits a snapshot of core results over an 8N1 UART line when the core signals completion. It sits beside `core` on the FPGA top level, taking the core's `completed`, `pc`, `preds` and `regs` outputs and sending them out of the board. A host can then check the same data the simulation bench prints: pc, prediction totals/successes/failures, and r00–r15. Each rising edge of `completed` produces exactly one fixed-length frame.

---
 rtl/result_dumper.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/result_dumper.sv
// Sends a fixed-length snapshot of core results (header, pc, prediction counters,
// register file) as little-endian bytes over an 8N1 UART, once per rising edge of completed.
module result_dumper #(
    parameter int CLK_PER_BIT = 868,
    parameter int NREGS       = 16
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              completed,
    input  logic [31:0]       pc,
    input  logic [2:0][31:0]  preds,
    input  logic [31:0][31:0] regs,
    output logic              txd,
    output logic              busy,
    output logic              done
);

    localparam int          NWORDS      = 4 + NREGS;
    localparam int          FRAME_BYTES = 1 + 4 * NWORDS;
    localparam logic [15:0] BIT_LAST    = 16'(CLK_PER_BIT - 1);
    localparam logic [7:0]  BYTE_LAST   = 8'(FRAME_BYTES - 1);
    localparam logic [7:0]  HEADER      = 8'hA5;

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_FIN} state_t;

    state_t              state_q, state_d;
    logic [15:0]         cnt_q, cnt_d;
    logic [2:0]          bit_q, bit_d;
    // 8 bits so that NREGS=32 (145 bytes) still fits the byte index
    logic [7:0]          byte_q, byte_d;
    logic                prev_q;
    logic                txd_q, txd_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [NWORDS*32-1:0] shadow_q, shadow_d, snapshot;
    logic                trigger;
    logic                bit_end;
    logic [7:0]          cur_byte;
    logic                unused_regs;

    assign trigger  = completed & ~prev_q;
    assign bit_end  = (cnt_q == BIT_LAST);
    // Shadow is a shift register: after the header, the low byte is always the next to send
    assign cur_byte = (byte_q == 8'd0) ? HEADER : shadow_q[7:0];
    assign unused_regs = ^regs;

    always_comb begin
        snapshot = '0;
        snapshot[31:0]   = pc;
        snapshot[63:32]  = preds[0];
        snapshot[95:64]  = preds[1];
        snapshot[127:96] = preds[2];
        for (int i = 0; i < NREGS; i++) begin
            snapshot[(4 + i) * 32 +: 32] = regs[i];
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        bit_d    = bit_q;
        byte_d   = byte_q;
        txd_d    = txd_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        shadow_d = shadow_q;
        case (state_q)
            S_IDLE: begin
                txd_d  = 1'b1;
                busy_d = 1'b0;
                if (trigger) begin
                    state_d  = S_START;
                    cnt_d    = '0;
                    bit_d    = '0;
                    byte_d   = '0;
                    txd_d    = 1'b0;
                    busy_d   = 1'b1;
                    shadow_d = snapshot;
                end
            end
            S_START: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    state_d = S_DATA;
                    txd_d   = cur_byte[0];
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    cnt_d = '0;
                    if (bit_q == 3'd7) begin
                        state_d = S_STOP;
                        txd_d   = 1'b1;
                    end else begin
                        bit_d = bit_q + 3'd1;
                        txd_d = cur_byte[bit_q + 3'd1];
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    cnt_d = '0;
                    bit_d = '0;
                    if (byte_q == BYTE_LAST) begin
                        state_d = S_FIN;
                        txd_d   = 1'b1;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        byte_d  = '0;
                    end else begin
                        state_d = S_START;
                        txd_d   = 1'b0;
                        byte_d  = byte_q + 8'd1;
                        if (byte_q != 8'd0) begin
                            shadow_d = shadow_q >> 8;
                        end
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
                txd_d   = 1'b1;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = S_IDLE;
                txd_d   = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            byte_q  <= '0;
            prev_q  <= 1'b0;
            txd_q   <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            byte_q  <= byte_d;
            prev_q  <= completed;
            txd_q   <= txd_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Snapshot data carries no reset; its contents only matter once a frame is loaded
    always_ff @(posedge clk) begin
        shadow_q <= shadow_d;
    end

    assign txd  = txd_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule
